alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
- Alarm controller sitting directly downstream of the hours/minutes/seconds time-of-day counter.
- Consumes the live Hours/Mins/Secs outputs and compares them against a user-programmed alarm time.
- Drives a buzzer through an IDLE/RINGING/SNOOZE state machine with bounded snooze count and ring timeout.
- Shares the counter's clock: one CLK cycle = one second.

Parameters:
- RING_SECS, 60: ring duration in cycles before auto-timeout; legal range 2..255.
- SNOOZE_MINS, 5: minutes added to current time on snooze; legal range 1..59.
- MAX_SNOOZES, 3: snoozes allowed per alarm event; legal range 0..3.

Ports:
- CLK  input  1  clock; one cycle per second.
- RST  input  1  reset, asynchronous, active-high.
- Hours  input  6  current hour, 0..23.
- Mins  input  6  current minute, 0..59.
- Secs  input  6  current second, 0..59.
- AlarmSet  input  1  load SetHours/SetMins into alarm registers.
- SetHours  input  6  new alarm hour.
- SetMins  input  6  new alarm minute.
- AlarmEn  input  1  arm alarm; level-sensitive.
- Snooze  input  1  snooze request; sampled per cycle.
- Stop  input  1  stop request; sampled per cycle.
- AlarmHours  output  6  programmed alarm hour.
- AlarmMins  output  6  programmed alarm minute.
- Ringing  output  1  high in RINGING.
- Snoozing  output  1  high in SNOOZE.
- Buzzer  output  1  buzzer drive.
- SnoozeCnt  output  2  snoozes used in current event.
- Chime  output  1  hourly chime pulse (optional feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; target TgtH:TgtM = 00:00; ring counter 0.
- AlarmSet:
  - Loads AlarmHours/AlarmMins and TgtH/TgtM only if SetHours<=23 and SetMins<=59; an out-of-range request is ignored entirely.
  - A valid load forces IDLE and clears SnoozeCnt.
  - A valid load takes priority over every other event in the same cycle.
- Match condition = AlarmEn & Hours==TgtH & Mins==TgtM & Secs==0.
- Transitions are registered; Ringing rises the cycle after the match cycle.
- IDLE:
  - Match -> RINGING; ring counter := 0.
- RINGING, priority order:
  - Stop -> IDLE.
  - AlarmEn low -> IDLE.
  - Snooze with SnoozeCnt<MAX_SNOOZES -> SNOOZE, SnoozeCnt+1, target := current time + SNOOZE_MINS. When SnoozeCnt==MAX_SNOOZES, Snooze is ignored.
  - Ring counter == RING_SECS-1 -> IDLE (timeout).
  - Otherwise ring counter +1.
- SNOOZE:
  - Stop or AlarmEn low -> IDLE.
  - Match on snooze target -> RINGING; ring counter := 0.
- Any return to IDLE (Stop, AlarmEn low, timeout):
  - clears SnoozeCnt;
  - restores TgtH:TgtM := AlarmHours:AlarmMins.
- Snooze arithmetic:
  - m = Mins + SNOOZE_MINS; if m>=60 then m-=60 and carry 1 into hours.
  - h = Hours + carry; if h>=24 then h=0.
  - Computed in 7-bit intermediates and truncated to 6 bits.
- Buzzer:
  - Registered.
  - 1 on the first RINGING cycle, then toggles every cycle while RINGING.
  - Forced 0 on the cycle state leaves RINGING and in all other states.
- Ringing and Snoozing are never both high.
- Asynchronous RST mid-ring returns all state and outputs to reset values immediately.

Optional Feature:
- Macro: ALARM_HOURLY_CHIME_EN.
- With it defined: Chime is a registered one-cycle pulse on the cycle after Mins==0 & Secs==0, independent of AlarmEn and of state. It is suppressed when Ringing is high in that same cycle.
- Without it: Chime is tied 0 and no chime logic is built.

Test Plan:
- Set alarm 07:30, AlarmEn=1, drive time 07:29:59 -> 07:30:00 -> Ringing=1 from the following cycle; Buzzer pattern 1,0,1,0...; after 60 ringing cycles Ringing=0 and SnoozeCnt=0.
- Ring at 23:58:00, assert Snooze at 23:58:03 -> Snoozing=1, SnoozeCnt=1; time reaches 00:03:00 -> Ringing=1 next cycle (wrap across midnight).
- Snooze three times (MAX_SNOOZES=3), then a 4th Snooze -> ignored; Ringing stays 1, SnoozeCnt=3; Stop -> IDLE, SnoozeCnt=0, target back to alarm time.
- Snooze and Stop asserted in the same cycle while RINGING -> IDLE; AlarmSet with SetHours=24 -> AlarmHours unchanged; AlarmSet in the same cycle as a match -> no ring.
- AlarmEn=0 at the alarm time -> no ring; RST pulsed mid-ring -> all outputs 0 immediately, AlarmHours=AlarmMins=0.
- With ALARM_HOURLY_CHIME_EN: time 09:59:59 -> 10:00:00 -> Chime high for exactly one cycle; without the macro, Chime stays 0.

Source files
------------

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm controller fed by the live time-of-day counter outputs.
// It compares the current time with a programmed alarm and drives a buzzer through an
// IDLE / RINGING / SNOOZE state machine. Snoozes per event are limited, and ringing
// stops by itself after a timeout. One CLK cycle is one second.
//
// Optional build macro:
//   ALARM_HOURLY_CHIME_EN  builds the hourly chime pulse. Without it, Chime is tied to 0.
//
// Ports:
//   CLK, RST               clock (1 Hz) and asynchronous active-high reset
//   Hours, Mins, Secs      current time of day
//   AlarmSet               load SetHours/SetMins (ignored if out of range)
//   SetHours, SetMins      new alarm time
//   AlarmEn                arm alarm (level)
//   Snooze, Stop           user requests, sampled every cycle
//   AlarmHours, AlarmMins  programmed alarm time
//   Ringing, Snoozing      state indicators (never both high)
//   Buzzer                 buzzer drive, toggling while ringing
//   SnoozeCnt              snoozes used in the current alarm event
//   Chime                  one-cycle hourly pulse (optional)
module alarm_ctrl #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_MINS = 5,
  parameter int unsigned MAX_SNOOZES = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Hours,
  input  logic [5:0] Mins,
  input  logic [5:0] Secs,
  input  logic       AlarmSet,
  input  logic [5:0] SetHours,
  input  logic [5:0] SetMins,
  input  logic       AlarmEn,
  input  logic       Snooze,
  input  logic       Stop,
  output logic [5:0] AlarmHours,
  output logic [5:0] AlarmMins,
  output logic       Ringing,
  output logic       Snoozing,
  output logic       Buzzer,
  output logic [1:0] SnoozeCnt,
  output logic       Chime
);

  localparam logic [7:0] RingLast = 8'(RING_SECS - 1);
  localparam logic [1:0] MaxSnz   = 2'(MAX_SNOOZES);
  localparam logic [6:0] SnzAdd   = 7'(SNOOZE_MINS);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

  state_e     state_q;
  logic [5:0] alarm_h_q, alarm_m_q;
  logic [5:0] tgt_h_q, tgt_m_q;
  logic [7:0] ring_cnt_q;
  logic [1:0] snooze_cnt_q;
  logic       buzzer_q;

  logic       set_ok;
  logic       match;
  logic [6:0] snz_m7, snz_h7;
  logic       snz_carry;
  logic       unused_snz_msb;

  assign set_ok = AlarmSet && (SetHours <= 6'd23) && (SetMins <= 6'd59);
  assign match  = AlarmEn && (Hours == tgt_h_q) && (Mins == tgt_m_q) && (Secs == 6'd0);

  // Snooze target = current time + SNOOZE_MINS, wrapping minutes and then hours.
  always_comb begin
    snz_carry = 1'b0;
    snz_m7    = {1'b0, Mins} + SnzAdd;
    if (snz_m7 >= 7'd60) begin
      snz_m7    = snz_m7 - 7'd60;
      snz_carry = 1'b1;
    end
    snz_h7 = {1'b0, Hours} + {6'd0, snz_carry};
    if (snz_h7 >= 7'd24) begin
      snz_h7 = 7'd0;
    end
  end

  // After wrapping, both results fit in 6 bits.
  assign unused_snz_msb = snz_m7[6] ^ snz_h7[6];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      alarm_h_q    <= '0;
      alarm_m_q    <= '0;
      tgt_h_q      <= '0;
      tgt_m_q      <= '0;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      buzzer_q     <= 1'b0;
    end else if (set_ok) begin
      // A valid load overrides any other event in the same cycle.
      state_q      <= StIdle;
      alarm_h_q    <= SetHours;
      alarm_m_q    <= SetMins;
      tgt_h_q      <= SetHours;
      tgt_m_q      <= SetMins;
      snooze_cnt_q <= '0;
      buzzer_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          buzzer_q <= 1'b0;
          if (match) begin
            state_q    <= StRing;
            ring_cnt_q <= '0;
            buzzer_q   <= 1'b1;
          end
        end
        StRing: begin
          if (Stop || !AlarmEn || (ring_cnt_q == RingLast)) begin
            // Stop, disarm or timeout. Snooze cannot win here because of the
            // priority order, except through the branch below.
            if (!Stop && AlarmEn && Snooze && (snooze_cnt_q < MaxSnz)) begin
              state_q      <= StSnooze;
              snooze_cnt_q <= snooze_cnt_q + 2'd1;
              tgt_h_q      <= snz_h7[5:0];
              tgt_m_q      <= snz_m7[5:0];
              buzzer_q     <= 1'b0;
            end else begin
              state_q      <= StIdle;
              snooze_cnt_q <= '0;
              tgt_h_q      <= alarm_h_q;
              tgt_m_q      <= alarm_m_q;
              buzzer_q     <= 1'b0;
            end
          end else if (Snooze && (snooze_cnt_q < MaxSnz)) begin
            state_q      <= StSnooze;
            snooze_cnt_q <= snooze_cnt_q + 2'd1;
            tgt_h_q      <= snz_h7[5:0];
            tgt_m_q      <= snz_m7[5:0];
            buzzer_q     <= 1'b0;
          end else begin
            ring_cnt_q <= ring_cnt_q + 8'd1;
            buzzer_q   <= ~buzzer_q;
          end
        end
        StSnooze: begin
          buzzer_q <= 1'b0;
          if (Stop || !AlarmEn) begin
            state_q      <= StIdle;
            snooze_cnt_q <= '0;
            tgt_h_q      <= alarm_h_q;
            tgt_m_q      <= alarm_m_q;
          end else if (match) begin
            state_q    <= StRing;
            ring_cnt_q <= '0;
            buzzer_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          buzzer_q <= 1'b0;
        end
      endcase
    end
  end

  assign AlarmHours = alarm_h_q;
  assign AlarmMins  = alarm_m_q;
  assign Ringing    = (state_q == StRing);
  assign Snoozing   = (state_q == StSnooze);
  assign Buzzer     = buzzer_q;
  assign SnoozeCnt  = snooze_cnt_q;

`ifdef ALARM_HOURLY_CHIME_EN
  logic chime_q;

  // Pulse on the top of every hour, unless the alarm is ringing at that moment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chime_q <= 1'b0;
    end else begin
      chime_q <= (Mins == 6'd0) && (Secs == 6'd0) && (state_q != StRing);
    end
  end

  assign Chime = chime_q;
`else
  assign Chime = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl. Each step drives one second of time and any control
// pulses. It then pushes the expected output snapshot to a scoreboard queue and pops and
// compares it after the clock edge.
module tb_alarm_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Hours, Mins, Secs;
  logic       AlarmSet;
  logic [5:0] SetHours, SetMins;
  logic       AlarmEn, Snooze, Stop;
  logic [5:0] AlarmHours, AlarmMins;
  logic       Ringing, Snoozing, Buzzer;
  logic [1:0] SnoozeCnt;
  logic       Chime;

`ifdef ALARM_HOURLY_CHIME_EN
  localparam bit ChimeEn = 1'b1;
`else
  localparam bit ChimeEn = 1'b0;
`endif

  alarm_ctrl #(
    .RING_SECS  (60),
    .SNOOZE_MINS(5),
    .MAX_SNOOZES(3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Hours     (Hours),
    .Mins      (Mins),
    .Secs      (Secs),
    .AlarmSet  (AlarmSet),
    .SetHours  (SetHours),
    .SetMins   (SetMins),
    .AlarmEn   (AlarmEn),
    .Snooze    (Snooze),
    .Stop      (Stop),
    .AlarmHours(AlarmHours),
    .AlarmMins (AlarmMins),
    .Ringing   (Ringing),
    .Snoozing  (Snoozing),
    .Buzzer    (Buzzer),
    .SnoozeCnt (SnoozeCnt),
    .Chime     (Chime)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [17:0] exp;
  } item_t;

  item_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    e_ah = 0;
  int    e_am = 0;
  bit    prev_ring = 1'b0;

  function automatic logic [17:0] pack(input int ah, input int am, input bit ring,
                                       input bit snz, input bit buz, input int cnt,
                                       input bit ch);
    return {6'(ah), 6'(am), ring, snz, buz, 2'(cnt), ch};
  endfunction

  function automatic logic [17:0] observe();
    return {AlarmHours, AlarmMins, Ringing, Snoozing, Buzzer, SnoozeCnt, Chime};
  endfunction

  task automatic check_pop();
    item_t it;
    logic [17:0] obs;
    it  = sb.pop_front();
    obs = observe();
    checks++;
    assert (obs === it.exp) else begin
      errors++;
      $error("FAIL %s: observed=%05h expected=%05h", it.tag, obs, it.exp);
    end
  endtask

  // One second of time. The expected values describe the outputs after this edge.
  task automatic step(input string tag, input int h, input int m, input int s,
                      input bit ring, input bit snz, input bit buz, input int cnt);
    bit ch;
    item_t it;
    Hours = 6'(h);
    Mins  = 6'(m);
    Secs  = 6'(s);
    ch = ChimeEn && (m == 0) && (s == 0) && !prev_ring;
    it.tag = tag;
    it.exp = pack(e_ah, e_am, ring, snz, buz, cnt, ch);
    sb.push_back(it);
    @(posedge CLK);
    #1;
    check_pop();
    prev_ring = ring;
    AlarmSet = 1'b0;
    Snooze   = 1'b0;
    Stop     = 1'b0;
  endtask

  task automatic check_now(input string tag);
    item_t it;
    it.tag = tag;
    it.exp = pack(e_ah, e_am, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    sb.push_back(it);
    check_pop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    Hours = 6'd12; Mins = 6'd34; Secs = 6'd56;
    AlarmSet = 1'b0; SetHours = '0; SetMins = '0;
    AlarmEn = 1'b0; Snooze = 1'b0; Stop = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_now("reset");
    RST = 1'b0;

    // Alarm 07:30, ring for exactly 60 cycles, then time out.
    AlarmEn = 1'b1;
    AlarmSet = 1'b1; SetHours = 6'd7; SetMins = 6'd30;
    e_ah = 7; e_am = 30;
    step("set0730", 7, 29, 58, 0, 0, 0, 0);
    step("pre", 7, 29, 59, 0, 0, 0, 0);
    step("ring_rise", 7, 30, 0, 1, 0, 1, 0);
    for (int i = 1; i < 60; i++) begin
      step($sformatf("ring_s%0d", i), 7, 30, i, 1, 0, (i % 2) == 0, 0);
    end
    step("timeout", 7, 31, 0, 0, 0, 0, 0);

    // Snooze across midnight: 23:58 + 5 -> 00:03.
    AlarmSet = 1'b1; SetHours = 6'd23; SetMins = 6'd58;
    e_ah = 23; e_am = 58;
    step("set2358", 23, 57, 0, 0, 0, 0, 0);
    step("ring2358", 23, 58, 0, 1, 0, 1, 0);
    step("ring_b0", 23, 58, 1, 1, 0, 0, 0);
    step("ring_b1", 23, 58, 2, 1, 0, 1, 0);
    Snooze = 1'b1;
    step("snooze1", 23, 58, 3, 0, 1, 0, 1);
    step("snz_wait", 23, 59, 0, 0, 1, 0, 1);
    step("snz_pre", 0, 2, 59, 0, 1, 0, 1);
    step("snz_ring", 0, 3, 0, 1, 0, 1, 1);
    Stop = 1'b1;
    step("stop1", 0, 3, 1, 0, 0, 0, 0);

    // Three snoozes, the fourth is ignored, then Stop.
    step("restored", 23, 58, 0, 1, 0, 1, 0);
    Snooze = 1'b1;
    step("sn1", 23, 58, 1, 0, 1, 0, 1);
    step("sn1_ring", 0, 3, 0, 1, 0, 1, 1);
    Snooze = 1'b1;
    step("sn2", 0, 3, 1, 0, 1, 0, 2);
    step("sn2_ring", 0, 8, 0, 1, 0, 1, 2);
    Snooze = 1'b1;
    step("sn3", 0, 8, 1, 0, 1, 0, 3);
    step("sn3_ring", 0, 13, 0, 1, 0, 1, 3);
    Snooze = 1'b1;
    step("sn4_ignored", 0, 13, 1, 1, 0, 0, 3);
    Stop = 1'b1;
    step("stop_cnt0", 0, 13, 2, 0, 0, 0, 0);

    // Snooze and Stop together, invalid set, set on a match cycle.
    step("tgt_back", 23, 58, 0, 1, 0, 1, 0);
    Snooze = 1'b1; Stop = 1'b1;
    step("snz_stop", 23, 58, 1, 0, 0, 0, 0);
    AlarmSet = 1'b1; SetHours = 6'd24; SetMins = 6'd10;
    step("bad_set", 23, 58, 2, 0, 0, 0, 0);
    AlarmSet = 1'b1; SetHours = 6'd6; SetMins = 6'd0;
    e_ah = 6; e_am = 0;
    step("set_vs_match", 23, 58, 0, 0, 0, 0, 0);
    step("no_ring", 23, 58, 1, 0, 0, 0, 0);
    step("ring0600", 6, 0, 0, 1, 0, 1, 0);
    AlarmEn = 1'b0;
    step("en_low", 6, 0, 1, 0, 0, 0, 0);

    // Disarmed at alarm time, then reset mid-ring.
    step("dis_match", 6, 0, 0, 0, 0, 0, 0);
    step("dis_after", 6, 0, 1, 0, 0, 0, 0);
    AlarmEn = 1'b1;
    step("rearm_ring", 6, 0, 0, 1, 0, 1, 0);
    step("rearm_b0", 6, 0, 1, 1, 0, 0, 0);
    #1;
    RST = 1'b1;
    #1;
    e_ah = 0; e_am = 0;
    check_now("async_rst");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    prev_ring = 1'b0;

    // Hourly chime, and its suppression while ringing.
    AlarmEn = 1'b0;
    step("pre_hour", 9, 59, 59, 0, 0, 0, 0);
    step("chime", 10, 0, 0, 0, 0, 0, 0);
    step("chime_off", 10, 0, 1, 0, 0, 0, 0);
    AlarmEn = 1'b1;
    AlarmSet = 1'b1; SetHours = 6'd10; SetMins = 6'd59;
    e_ah = 10; e_am = 59;
    step("set1059", 10, 58, 59, 0, 0, 0, 0);
    step("ring1059", 10, 59, 0, 1, 0, 1, 0);
    step("chime_supp", 11, 0, 0, 1, 0, 0, 0);
    step("ring_b1b", 11, 0, 1, 1, 0, 1, 0);
    Stop = 1'b1;
    step("final_stop", 11, 0, 2, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
